// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: round-robin two-requester sequencer sharing one AXI-Lite master port,
// one transaction outstanding at a time, with a sticky per-handshake stall watchdog.
module axil_master_arbiter #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int MAX_WAIT         = 5
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [1:0]                    REQ_VALID,
    input  logic [1:0]                    REQ_WRITE,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*C_AXI_DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]                    REQ_READY,
    output logic [1:0]                    REQ_DONE,
    output logic [C_AXI_DATA_WIDTH-1:0]   REQ_RDATA,
    output logic [1:0]                    REQ_RESP,
    output logic                          TIMEOUT_ERR,
    output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    output logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]                    AXI_RRESP,
    input  logic                          AXI_RVALID,
    output logic                          AXI_RREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    output logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    output logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    output logic                          AXI_BREADY
);
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t        state_q;
    logic          last_q, grant_q, gnt, hs;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        gnt   = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
        hs    = (state_q == RD_ADDR && AXI_ARREADY) || (state_q == RD_DATA && AXI_RVALID) ||
                (state_q == WR_ADDR && ((AXI_AWVALID && AXI_AWREADY) || (AXI_WVALID && AXI_WREADY))) ||
                (state_q == WR_RESP && AXI_BVALID);
        cnt_d = (state_q == IDLE || hs) ? '0 : (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
    end
    assign REQ_READY = (state_q == IDLE && REQ_VALID != 2'b00) ? {gnt, ~gnt} : 2'b00;
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            cnt_q       <= '0;
            REQ_DONE    <= 2'b00;
            REQ_RDATA   <= '0;
            REQ_RESP    <= 2'b00;
            TIMEOUT_ERR <= 1'b0;
            AXI_ARADDR  <= '0;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
            AXI_AWADDR  <= '0;
            AXI_AWVALID <= 1'b0;
            AXI_WDATA   <= '0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
        end else begin
            REQ_DONE <= 2'b00;
            cnt_q    <= cnt_d;
            if (cnt_d == CW'(MAX_WAIT)) TIMEOUT_ERR <= 1'b1;
            case (state_q)
                IDLE: if (REQ_VALID != 2'b00) begin
                    grant_q <= gnt;
                    last_q  <= gnt;
                    if (REQ_WRITE[gnt]) begin
                        AXI_AWADDR  <= gnt ? REQ_ADDR[AW +: AW] : REQ_ADDR[0 +: AW];
                        AXI_WDATA   <= gnt ? REQ_WDATA[DW +: DW] : REQ_WDATA[0 +: DW];
                        AXI_AWVALID <= 1'b1;
                        AXI_WVALID  <= 1'b1;
                        state_q     <= WR_ADDR;
                    end else begin
                        AXI_ARADDR  <= gnt ? REQ_ADDR[AW +: AW] : REQ_ADDR[0 +: AW];
                        AXI_ARVALID <= 1'b1;
                        state_q     <= RD_ADDR;
                    end
                end
                RD_ADDR: if (AXI_ARREADY) begin
                    AXI_ARVALID <= 1'b0;
                    AXI_RREADY  <= 1'b1;
                    state_q     <= RD_DATA;
                end
                RD_DATA: if (AXI_RVALID) begin
                    AXI_RREADY <= 1'b0;
                    REQ_RDATA  <= AXI_RDATA;
                    REQ_RESP   <= AXI_RRESP;
                    REQ_DONE   <= {grant_q, ~grant_q};
                    state_q    <= IDLE;
                end
                WR_ADDR: begin
                    // AW and W retire independently; move on once neither is still pending
                    AXI_AWVALID <= AXI_AWVALID && !AXI_AWREADY;
                    AXI_WVALID  <= AXI_WVALID && !AXI_WREADY;
                    if ((!AXI_AWVALID || AXI_AWREADY) && (!AXI_WVALID || AXI_WREADY)) begin
                        AXI_BREADY <= 1'b1;
                        state_q    <= WR_RESP;
                    end
                end
                WR_RESP: if (AXI_BVALID) begin
                    AXI_BREADY <= 1'b0;
                    REQ_RESP   <= AXI_BRESP;
                    REQ_DONE   <= {grant_q, ~grant_q};
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
